// File: rtl/ndn_pkg.sv
// ndn_pkg: shared constants, type/error codes and FSM encoding for the
// SPI prefix assembler and the prefix mask helper.
// Optional feature macro: PREFIX_CHECKSUM_EN (adds the CHECK state encoding).
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;
    localparam int META_W   = 8;

    localparam logic [1:0] TYPE_INTEREST = 2'b00;
    localparam logic [1:0] TYPE_DATA     = 2'b01;
    localparam logic [1:0] TYPE_CTRL     = 2'b10;
    localparam logic [1:0] TYPE_RSVD     = 2'b11;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_TYPE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
`ifdef PREFIX_CHECKSUM_EN
        ST_CHECK  = 3'd2,
`endif
        ST_EMIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    function automatic logic [META_W-1:0] pack_meta(input logic [1:0]       frame_type,
                                                    input logic [LEN_W-1:0] len);
        return {frame_type, len};
    endfunction

endpackage

// File: rtl/prefix_len_mask.sv
// prefix_len_mask: combinational keep-mask for a left-aligned prefix.
// Ports:
//   len  in  6   prefix bit length minus 1
//   mask out 64  ones in bits [63:63-len], zeros below
module prefix_len_mask
    import ndn_pkg::*;
(
    input  logic [LEN_W-1:0]    len,
    output logic [PREFIX_W-1:0] mask
);

    // 63-len never underflows in 6 bits; len=63 gives a shift of 0 (all ones).
    assign mask = {PREFIX_W{1'b1}} << (6'd63 - len);

endmodule

// File: rtl/spi_prefix_assembler.sv
// spi_prefix_assembler: collects a header byte {type, len} and len[5:3]+1
// prefix bytes from the SPI byte stream, emits a masked left-aligned 64-bit
// prefix to the PIT with a one-cycle out_bit strobe, then blocks SPI input
// for HOLD_CYCLES cycles while the PIT looks it up.
// Ports:
//   clk, rst (async active-low)
//   spi_byte/spi_byte_valid/spi_byte_ready : byte stream in (valid/ready)
//   SPI_to_PIT_prefix, length, metadata    : registered frame result
//   out_bit     : one-cycle result strobe
//   frame_error : one-cycle abort strobe, err_code holds the last cause
//   pkt_count   : emitted frame count (wraps)
// Optional feature macro: PREFIX_CHECKSUM_EN -- expects a trailing XOR
// checksum byte (header ^ prefix bytes) before emitting.
//
// state  | meaning
// IDLE   | waiting for header byte
// PREFIX | collecting prefix bytes
// CHECK  | waiting for checksum byte (PREFIX_CHECKSUM_EN only)
// EMIT   | out_bit strobe cycle, reload hold counter
// HOLD   | input blocked during PIT lookup
module spi_prefix_assembler
    import ndn_pkg::*;
#(
    parameter int HOLD_CYCLES    = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          spi_byte,
    input  logic                spi_byte_valid,
    output logic                spi_byte_ready,
    output logic [PREFIX_W-1:0] SPI_to_PIT_prefix,
    output logic [LEN_W-1:0]    length,
    output logic [META_W-1:0]   metadata,
    output logic                out_bit,
    output logic                frame_error,
    output logic [1:0]          err_code,
    output logic [15:0]         pkt_count
);

    state_t              state;
    logic [1:0]          type_q;
    logic [LEN_W-1:0]    len_q;
    logic [2:0]          k_q;
    logic [PREFIX_W-1:0] prefix_q;
    logic [15:0]         gap_q;
    logic [7:0]          hold_q;
`ifdef PREFIX_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                xfer;
    logic                gap_expired;
    logic [PREFIX_W-1:0] keep_mask;
    logic [PREFIX_W-1:0] prefix_ins;

    assign xfer        = spi_byte_valid && spi_byte_ready;
    assign gap_expired = (gap_q == 16'(TIMEOUT_CYCLES - 1));

    // Register is cleared at header time, so OR-ing the shifted byte in
    // is equivalent to writing bits [63-8k -: 8].
    assign prefix_ins  = prefix_q | ({spi_byte, 56'b0} >> {k_q, 3'b000});

    prefix_len_mask u_mask (
        .len  (len_q),
        .mask (keep_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            type_q            <= '0;
            len_q             <= '0;
            k_q               <= '0;
            prefix_q          <= '0;
            gap_q             <= '0;
            hold_q            <= '0;
`ifdef PREFIX_CHECKSUM_EN
            csum_q            <= '0;
`endif
            spi_byte_ready    <= 1'b0;
            SPI_to_PIT_prefix <= '0;
            length            <= '0;
            metadata          <= '0;
            out_bit           <= 1'b0;
            frame_error       <= 1'b0;
            err_code          <= ERR_NONE;
            pkt_count         <= '0;
        end else begin
            out_bit     <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    spi_byte_ready <= 1'b1;
                    if (xfer) begin
                        if (spi_byte[7:6] == TYPE_RSVD) begin
                            frame_error <= 1'b1;
                            err_code    <= ERR_BAD_TYPE;
                        end else begin
                            type_q   <= spi_byte[7:6];
                            len_q    <= spi_byte[5:0];
                            prefix_q <= '0;
                            k_q      <= '0;
                            gap_q    <= '0;
`ifdef PREFIX_CHECKSUM_EN
                            csum_q   <= spi_byte;
`endif
                            state    <= ST_PREFIX;
                        end
                    end
                end
                ST_PREFIX: begin
                    if (xfer) begin
                        prefix_q <= prefix_ins;
                        k_q      <= k_q + 3'd1;
                        gap_q    <= '0;
`ifdef PREFIX_CHECKSUM_EN
                        csum_q   <= csum_q ^ spi_byte;
                        if (k_q == len_q[5:3]) begin
                            state <= ST_CHECK;
                        end
`else
                        if (k_q == len_q[5:3]) begin
                            // Result registers load on this edge so out_bit
                            // is visible during the EMIT cycle.
                            SPI_to_PIT_prefix <= prefix_ins & keep_mask;
                            length            <= len_q;
                            metadata          <= pack_meta(type_q, len_q);
                            out_bit           <= 1'b1;
                            pkt_count         <= pkt_count + 16'd1;
                            spi_byte_ready    <= 1'b0;
                            state             <= ST_EMIT;
                        end
`endif
                    end else if (gap_expired) begin
                        frame_error <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
`ifdef PREFIX_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer) begin
                        gap_q <= '0;
                        if (spi_byte == csum_q) begin
                            SPI_to_PIT_prefix <= prefix_q & keep_mask;
                            length            <= len_q;
                            metadata          <= pack_meta(type_q, len_q);
                            out_bit           <= 1'b1;
                            pkt_count         <= pkt_count + 16'd1;
                            spi_byte_ready    <= 1'b0;
                            state             <= ST_EMIT;
                        end else begin
                            frame_error <= 1'b1;
                            err_code    <= ERR_CHECKSUM;
                            state       <= ST_IDLE;
                        end
                    end else if (gap_expired) begin
                        frame_error <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
`endif
                ST_EMIT: begin
                    hold_q <= 8'(HOLD_CYCLES - 1);
                    state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_q == 8'd0) begin
                        spi_byte_ready <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q - 8'd1;
                    end
                end
                default: begin
                    spi_byte_ready <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_prefix_assembler.md
Name: spi_prefix_assembler

Overview:
- Sits between the SPI byte receiver and pit_hash_table.
- Collects a framed interest/data header and prefix bytes from SPI into a 64-bit left-aligned prefix with a length and metadata byte.
- Presents the result to the PIT with a single-cycle out_bit strobe, then holds off SPI input while the PIT does its lookup.
- Aborts malformed or stalled frames and reports the error.

Parameters:
- HOLD_CYCLES, 6: cycles spi_byte_ready stays low after the out_bit strobe (PIT lookup window); legal range 1..255.
- TIMEOUT_CYCLES, 255: maximum idle cycles between accepted bytes inside a frame before abort; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- spi_byte  in  8  byte from SPI receiver.
- spi_byte_valid  in  1  spi_byte is valid this cycle.
- spi_byte_ready  out  1  block accepts a byte this cycle (transfer = valid && ready).
- SPI_to_PIT_prefix  out  64  assembled prefix, MSB-first, unused low bits zero.
- length  out  6  prefix bit length minus 1 (63 = full 64 bits).
- metadata  out  8  {type[1:0], length[5:0]} of the emitted frame.
- out_bit  out  1  one-cycle strobe: prefix/length/metadata valid.
- frame_error  out  1  one-cycle strobe on aborted frame.
- err_code  out  2  cause of last abort: 01 bad type, 10 timeout, 11 checksum; holds until next abort.
- pkt_count  out  16  count of emitted frames, wraps at 65535 to 0.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except spi_byte_ready=0 while in reset; partial frame discarded, no strobe generated.
- Frame: header byte {type[7:6], len[5:0]}, then N=len[5:3]+1 prefix bytes, MSB first.
- Types: 00 interest, 01 data, 10 control (all emitted); 11 reserved.
- States: IDLE, PREFIX, CHECK (only with macro), EMIT, HOLD.
- IDLE:
  - spi_byte_ready=1.
  - On transfer: type 11 -> frame_error=1 next cycle, err_code=01, stay IDLE.
  - Otherwise latch type/len, clear prefix register and byte index k=0, go to PREFIX.
- PREFIX:
  - spi_byte_ready=1.
  - On transfer, write byte into bits [63-8k -: 8] and increment k.
  - On the Nth byte, go to EMIT (or CHECK with macro).
- EMIT:
  - spi_byte_ready=0.
  - Drive out_bit=1 for exactly this cycle, with the prefix masked so bits [62-len:0] are 0 (no mask when len=63).
  - Increment pkt_count; go to HOLD.
- Latency: out_bit rises on the clock edge after the last frame byte is accepted.
- Output hold: SPI_to_PIT_prefix, length and metadata are registered and hold their values until the next EMIT.
- HOLD:
  - spi_byte_ready=0 for HOLD_CYCLES cycles (counter reloads in EMIT), then go to IDLE.
  - Bytes offered during HOLD are not consumed; the upstream block keeps valid asserted.
- Timeout:
  - In PREFIX/CHECK, the gap counter clears on each transfer and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: frame_error strobe, err_code=10, go to IDLE, no out_bit.
- Boundaries:
  - len=0 -> 1 byte, only bit 63 kept.
  - len=7 -> 1 byte.
  - len=8 -> 2 bytes.
  - Back-to-back valid bytes are accepted every cycle in IDLE/PREFIX.
  - frame_error and out_bit are never asserted in the same cycle.

Optional Feature:
- Macro: PREFIX_CHECKSUM_EN.
- Defined:
  - After the prefix bytes, one checksum byte is expected, equal to the XOR of the header and all prefix bytes; it is received in CHECK.
  - Match -> EMIT.
  - Mismatch -> frame_error, err_code=11, IDLE, no emit.
  - Latency becomes one byte longer.
- Undefined: CHECK state and checksum logic are absent; err_code 11 is never produced.

Decomposition:
- Package ndn_pkg holds:
  - constants PREFIX_W=64, LEN_W=6, META_W=8;
  - type codes TYPE_INTEREST=2'b00, TYPE_DATA=2'b01, TYPE_CTRL=2'b10, TYPE_RSVD=2'b11;
  - err_code values;
  - the state encoding.
- One sub-module, prefix_len_mask: purely combinational, len[5:0] -> 64-bit keep-mask, reusable by the FIB side.

Test Plan:
- Header 0x3F followed by bytes 24 FD BF 80 A6 EF 7D A7 -> one cycle later out_bit=1, prefix=0x24FDBF80A6EF7DA7, length=63, metadata=0x3F, pkt_count=1, then spi_byte_ready=0 for 6 cycles.
- Header 0x4B (data, len=11) followed by bytes FF FF -> prefix=0xFFF0000000000000, metadata=0x4B.
- Header 0xC0 -> frame_error one cycle, err_code=01, no out_bit, next header accepted immediately.
- Header 0x3F, 3 bytes, then valid low for 255 cycles -> frame_error, err_code=10, no out_bit; the following full frame emits correctly.
- Drop rst low mid-PREFIX -> all outputs 0 asynchronously; after release, a new full frame emits with no residue from the old frame.
- With PREFIX_CHECKSUM_EN, header 0x07, byte 0xA5, checksum 0xA2 -> emit prefix=0xA500000000000000. Same frame with checksum 0x00 -> err_code=11, no emit.
